// File: rtl/color_scan_ctrl.sv
// color_scan_ctrl: runs one color scan of a frequency-output color sensor.
// Each of the four filters (red, blue, clear, green) gets a settle window
// followed by a gate window. Sensor rising edges seen during the gate window
// are counted, and the four counts are published together when the scan ends.
//
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   sensor              asynchronous sensor frequency output
//   start               scan request, sampled only while idle
//   cont                rescan automatically after each result
//   abort               cancel a scan in progress
//   scale               frequency-scaling code, latched when a scan begins
//   s_scale             sensor S0,S1 (00 = powered down while idle)
//   s_filt              sensor S2,S3 filter select
//   busy                scan in progress
//   valid               one-cycle pulse when cnt_* are updated
//   cnt_r/b/c/g         per-filter edge counts from the last completed scan
module color_scan_ctrl #(
   parameter int unsigned CNT_W         = 16,
   parameter int unsigned SETTLE_CYCLES = 5000,
   parameter int unsigned GATE_CYCLES   = 100000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             sensor,
   input  logic             start,
   input  logic             cont,
   input  logic             abort,
   input  logic [1:0]       scale,
   output logic [1:0]       s_scale,
   output logic [1:0]       s_filt,
   output logic             busy,
   output logic             valid,
   output logic [CNT_W-1:0] cnt_r,
   output logic [CNT_W-1:0] cnt_b,
   output logic [CNT_W-1:0] cnt_c,
   output logic [CNT_W-1:0] cnt_g
);

   localparam int unsigned TMR_MAX = (SETTLE_CYCLES > GATE_CYCLES) ? SETTLE_CYCLES : GATE_CYCLES;
   localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

   localparam logic [1:0] ST_IDLE   = 2'b00;
   localparam logic [1:0] ST_SETTLE = 2'b01;
   localparam logic [1:0] ST_GATE   = 2'b10;
   localparam logic [1:0] ST_DONE   = 2'b11;

   logic [1:0]            r_state,  w_state_nxt;
   logic [TMR_W-1:0]      r_tmr,    w_tmr_nxt;
   logic [1:0]            r_filt,   w_filt_nxt;
   logic [1:0]            r_s_scale, w_scale_nxt;
   logic                  r_busy,   w_busy_nxt;
   logic                  r_valid,  w_valid_nxt;
   logic [CNT_W-1:0]      r_work,   w_work_nxt;
   logic [3:0][CNT_W-1:0] r_shadow, w_shadow_nxt;
   logic [3:0][CNT_W-1:0] r_cnt,    w_cnt_nxt;
   logic                  r_sync1, r_sync2, r_sync_d;
   logic                  w_det;
   logic [CNT_W-1:0]      w_work_inc;
   logic                  w_launch;
   logic                  w_to_idle;

   // One detect pulse per synchronized rising edge
   assign w_det = r_sync2 & ~r_sync_d;

   // Working count plus this cycle's edge, held at all-ones instead of wrapping
   assign w_work_inc = (w_det && (r_work != '1)) ? r_work + CNT_W'(1) : r_work;

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_tmr     <= '0;
         r_filt    <= 2'b00;
         r_s_scale <= 2'b00;
         r_busy    <= 1'b0;
         r_valid   <= 1'b0;
         r_work    <= '0;
         r_shadow  <= '0;
         r_cnt     <= '0;
         r_sync1   <= 1'b0;
         r_sync2   <= 1'b0;
         r_sync_d  <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_tmr     <= w_tmr_nxt;
         r_filt    <= w_filt_nxt;
         r_s_scale <= w_scale_nxt;
         r_busy    <= w_busy_nxt;
         r_valid   <= w_valid_nxt;
         r_work    <= w_work_nxt;
         r_shadow  <= w_shadow_nxt;
         r_cnt     <= w_cnt_nxt;
         r_sync1   <= sensor;
         r_sync2   <= r_sync1;
         r_sync_d  <= r_sync2;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      w_state_nxt  = r_state;
      w_tmr_nxt    = r_tmr;
      w_filt_nxt   = r_filt;
      w_scale_nxt  = r_s_scale;
      w_work_nxt   = r_work;
      w_shadow_nxt = r_shadow;
      w_cnt_nxt    = r_cnt;
      w_valid_nxt  = 1'b0;
      w_launch     = 1'b0;
      w_to_idle    = 1'b0;

      case (r_state)
         ST_IDLE: begin
            w_launch = start && !abort;
         end
         ST_SETTLE: begin
            if (abort) begin
               w_to_idle    = 1'b1;
               w_shadow_nxt = '0;
            end else if (r_tmr == TMR_W'(SETTLE_CYCLES - 1)) begin
               w_state_nxt = ST_GATE;
               w_tmr_nxt   = '0;
            end else begin
               w_tmr_nxt = r_tmr + TMR_W'(1);
            end
         end
         ST_GATE: begin
            if (abort) begin
               w_to_idle    = 1'b1;
               w_shadow_nxt = '0;
            end else if (r_tmr == TMR_W'(GATE_CYCLES - 1)) begin
               // Last gate cycle: its own edge is folded into the stored count
               w_shadow_nxt[r_filt] = w_work_inc;
               w_work_nxt           = '0;
               w_tmr_nxt            = '0;
               if (r_filt == 2'b11) begin
                  w_state_nxt = ST_DONE;
               end else begin
                  w_filt_nxt  = r_filt + 2'd1;
                  w_state_nxt = ST_SETTLE;
               end
            end else begin
               w_work_nxt = w_work_inc;
               w_tmr_nxt  = r_tmr + TMR_W'(1);
            end
         end
         ST_DONE: begin
            // Results publish even when abort arrives here; abort only blocks the rescan
            w_valid_nxt = 1'b1;
            w_cnt_nxt   = r_shadow;
            if (cont && !abort) begin
               w_launch = 1'b1;
            end else begin
               w_to_idle = 1'b1;
            end
         end
         default: begin
            w_to_idle = 1'b1;
         end
      endcase

      if (w_launch) begin
         w_state_nxt = ST_SETTLE;
         w_scale_nxt = scale;
         w_filt_nxt  = 2'b00;
         w_work_nxt  = '0;
         w_tmr_nxt   = '0;
      end

      if (w_to_idle) begin
         w_state_nxt = ST_IDLE;
         w_scale_nxt = 2'b00;
         w_filt_nxt  = 2'b00;
         w_work_nxt  = '0;
         w_tmr_nxt   = '0;
      end

      w_busy_nxt = (w_state_nxt != ST_IDLE);
   end

   assign s_scale = r_s_scale;
   assign s_filt  = r_filt;
   assign busy    = r_busy;
   assign valid   = r_valid;
   assign cnt_r   = r_cnt[0];
   assign cnt_b   = r_cnt[1];
   assign cnt_c   = r_cnt[2];
   assign cnt_g   = r_cnt[3];

endmodule

// File: tb/tb_color_scan_ctrl.sv
// tb_color_scan_ctrl: self-checking bench for color_scan_ctrl.
// Two instances share all inputs: an 8-bit counter build and a 5-bit one
// used to observe saturation. Expected counts come from a list of the
// counting clock edge of every sensor rise the bench produces, binned into
// each filter's gate window.
`timescale 1ns/1ps
module tb_color_scan_ctrl;

   localparam int S    = 4;
   localparam int G    = 100;
   localparam int P    = S + G;
   localparam int SCAN = 4 * P;

   logic       clk;
   logic       rst_n;
   logic       sensor;
   logic       start;
   logic       cont;
   logic       abort;
   logic [1:0] scale;
   logic [1:0] s_scale, s_filt, s_scale5, s_filt5;
   logic       busy, valid, busy5, valid5;
   logic [7:0] cnt_r, cnt_b, cnt_c, cnt_g;
   logic [4:0] cnt5_r, cnt5_b, cnt5_c, cnt5_g;

   int          errors = 0;
   int          checks = 0;
   int          cyc    = 0;
   int          rise_q[$];
   int          prev[4];
   logic [31:0] exp8;
   logic [19:0] exp5;

   color_scan_ctrl #(.CNT_W(8), .SETTLE_CYCLES(S), .GATE_CYCLES(G)) dut (
      .clk(clk), .rst_n(rst_n), .sensor(sensor), .start(start), .cont(cont),
      .abort(abort), .scale(scale), .s_scale(s_scale), .s_filt(s_filt),
      .busy(busy), .valid(valid), .cnt_r(cnt_r), .cnt_b(cnt_b),
      .cnt_c(cnt_c), .cnt_g(cnt_g));

   color_scan_ctrl #(.CNT_W(5), .SETTLE_CYCLES(S), .GATE_CYCLES(G)) dut5 (
      .clk(clk), .rst_n(rst_n), .sensor(sensor), .start(start), .cont(cont),
      .abort(abort), .scale(scale), .s_scale(s_scale5), .s_filt(s_filt5),
      .busy(busy5), .valid(valid5), .cnt_r(cnt5_r), .cnt_b(cnt5_b),
      .cnt_c(cnt5_c), .cnt_g(cnt5_g));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog time limit reached at cyc=%0d", cyc);
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      cyc++;
      #1;
   endtask

   function automatic int sat(input int v, input int m);
      return (v > m) ? m : v;
   endfunction

   task automatic set_prev(input int a, input int b, input int c, input int d);
      prev[0] = a; prev[1] = b; prev[2] = c; prev[3] = d;
      exp8 = {8'(sat(a, 255)), 8'(sat(b, 255)), 8'(sat(c, 255)), 8'(sat(d, 255))};
      exp5 = {5'(sat(a, 31)), 5'(sat(b, 31)), 5'(sat(c, 31)), 5'(sat(d, 31))};
   endtask

   // Rises whose counting edge lies in filter f's gate window
   function automatic int model_count(input int c0, input int f);
      int n;
      int lo;
      int hi;
      n  = 0;
      lo = c0 + f * P + S + 1;
      hi = c0 + (f + 1) * P;
      foreach (rise_q[i]) if (rise_q[i] >= lo && rise_q[i] <= hi) n++;
      return n;
   endfunction

   // 0: square wave of half-period half; 1: pulses only in settle windows; 2: noise
   function automatic logic pattern(input int mode, input int half, input int c0, input int t);
      int pos;
      pos = (t + 3 - c0) % P;
      case (mode)
         0:       return 1'((t / half) % 2);
         1:       return (pos == 1) || (pos == 2);
         default: return 1'($urandom_range(0, 1));
      endcase
   endfunction

   // A rise driven after edge n is counted at edge n+3 (two sync flops + edge flop)
   task automatic drive_sensor(input logic v);
      if (v && !sensor) rise_q.push_back(cyc + 3);
      sensor = v;
   endtask

   task automatic run_scan(input bit chained, input int mode, input int half,
                           input logic [1:0] scl, input bit cont_val,
                           input logic [1:0] next_scl, input int abort_rel,
                           input int rst_rel);
      int         c0;
      int         ex[4];
      bit         cont_exp;
      bit         saw_bad;
      logic [1:0] ef;
      cont = cont_val;
      if (!chained) begin
         start = 1'b1;
         scale = scl;
         tick();
         start = 1'b0;
      end
      c0 = cyc;
      rise_q.delete();
      cont_exp = cont_val && (abort_rel != SCAN);
      for (int rel = 0; rel <= SCAN + 1; rel++) begin
         if (rel > 0) tick();
         if (rel <= SCAN && !(chained && rel == 0)) begin
            ef = (rel >= 3 * P) ? 2'd3 : 2'(rel / P);
            checks++;
            if (busy !== 1'b1) begin errors++; $display("FAIL busy_in_scan rel=%0d got=%b exp=1", rel, busy); end
            checks++;
            if (s_scale !== scl) begin errors++; $display("FAIL s_scale_in_scan rel=%0d got=%b exp=%b", rel, s_scale, scl); end
            checks++;
            if (s_filt !== ef) begin errors++; $display("FAIL s_filt_seq rel=%0d got=%b exp=%b", rel, s_filt, ef); end
            checks++;
            if (valid !== 1'b0) begin errors++; $display("FAIL valid_early rel=%0d got=%b exp=0", rel, valid); end
            checks++;
            if ({cnt_r, cnt_b, cnt_c, cnt_g} !== exp8) begin
               errors++; $display("FAIL cnt_hold rel=%0d got=%h exp=%h", rel, {cnt_r, cnt_b, cnt_c, cnt_g}, exp8);
            end
         end
         if (rel == SCAN + 1) begin
            for (int f = 0; f < 4; f++) ex[f] = model_count(c0, f);
            set_prev(ex[0], ex[1], ex[2], ex[3]);
            checks++;
            if (valid !== 1'b1) begin errors++; $display("FAIL valid_latency got=%b exp=1 at start+%0d", valid, rel); end
            checks++;
            if (valid5 !== 1'b1) begin errors++; $display("FAIL valid5_latency got=%b exp=1", valid5); end
            checks++;
            if ({cnt_r, cnt_b, cnt_c, cnt_g} !== exp8) begin
               errors++; $display("FAIL cnt8_result got=%h exp=%h", {cnt_r, cnt_b, cnt_c, cnt_g}, exp8);
            end
            checks++;
            if ({cnt5_r, cnt5_b, cnt5_c, cnt5_g} !== exp5) begin
               errors++; $display("FAIL cnt5_result got=%h exp=%h", {cnt5_r, cnt5_b, cnt5_c, cnt5_g}, exp5);
            end
            checks++;
            if (busy !== cont_exp) begin errors++; $display("FAIL busy_after_done got=%b exp=%b", busy, cont_exp); end
            checks++;
            if (s_scale !== (cont_exp ? next_scl : 2'b00)) begin
               errors++; $display("FAIL s_scale_after_done got=%b exp=%b", s_scale, cont_exp ? next_scl : 2'b00);
            end
         end
         if (rel == abort_rel && rel < SCAN) begin
            abort = 1'b1;
            start = 1'b1;
            tick();
            abort = 1'b0;
            start = 1'b0;
            checks++;
            if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
            checks++;
            if (s_scale !== 2'b00) begin errors++; $display("FAIL abort_s_scale got=%b exp=00", s_scale); end
            checks++;
            if (valid !== 1'b0) begin errors++; $display("FAIL abort_valid got=%b exp=0", valid); end
            saw_bad = 1'b0;
            repeat (SCAN + 20) begin
               tick();
               drive_sensor(pattern(mode, half, c0, cyc));
               if (valid !== 1'b0 || busy !== 1'b0) saw_bad = 1'b1;
            end
            checks++;
            if (saw_bad) begin errors++; $display("FAIL abort_no_valid got=activity exp=idle"); end
            checks++;
            if ({cnt_r, cnt_b, cnt_c, cnt_g} !== exp8) begin
               errors++; $display("FAIL abort_cnt_keep got=%h exp=%h", {cnt_r, cnt_b, cnt_c, cnt_g}, exp8);
            end
            cont = 1'b0;
            return;
         end
         if (rel == rst_rel) begin
            rst_n = 1'b0;
            start = 1'b0;
            #1;
            set_prev(0, 0, 0, 0);
            checks++;
            if ({busy, valid, s_scale, s_filt} !== 6'b0) begin
               errors++; $display("FAIL async_reset_ctrl got=%b exp=000000", {busy, valid, s_scale, s_filt});
            end
            checks++;
            if ({cnt_r, cnt_b, cnt_c, cnt_g} !== exp8) begin
               errors++; $display("FAIL async_reset_cnt got=%h exp=%h", {cnt_r, cnt_b, cnt_c, cnt_g}, exp8);
            end
            checks++;
            if ({cnt5_r, cnt5_b, cnt5_c, cnt5_g} !== exp5) begin
               errors++; $display("FAIL async_reset_cnt5 got=%h exp=%h", {cnt5_r, cnt5_b, cnt5_c, cnt5_g}, exp5);
            end
            repeat (3) tick();
            rst_n = 1'b1;
            repeat (10) tick();
            checks++;
            if ({busy, valid, s_scale} !== 4'b0) begin
               errors++; $display("FAIL idle_after_reset got=%b exp=0000", {busy, valid, s_scale});
            end
            cont = 1'b0;
            return;
         end
         drive_sensor(pattern(mode, half, c0, cyc));
         if (rel < SCAN - 2) begin
            start = 1'($urandom_range(0, 1));
            scale = 2'($urandom_range(0, 3));
         end else begin
            start = 1'b0;
            scale = next_scl;
         end
         abort = (rel == SCAN) && (abort_rel == SCAN);
      end
      abort = 1'b0;
      cont  = 1'b0;
      if (!cont_exp) begin
         tick();
         checks++;
         if (valid !== 1'b0) begin errors++; $display("FAIL valid_one_cycle got=%b exp=0", valid); end
         checks++;
         if (busy !== 1'b0) begin errors++; $display("FAIL busy_idle got=%b exp=0", busy); end
      end
   endtask

   task automatic test_reset();
      rst_n  = 1'b0;
      sensor = 1'b0;
      start  = 1'b0;
      cont   = 1'b0;
      abort  = 1'b0;
      scale  = 2'b00;
      set_prev(0, 0, 0, 0);
      repeat (3) tick();
      checks++;
      if ({busy, valid, s_scale, s_filt} !== 6'b0) begin
         errors++; $display("FAIL reset_ctrl got=%b exp=000000", {busy, valid, s_scale, s_filt});
      end
      checks++;
      if ({cnt_r, cnt_b, cnt_c, cnt_g} !== exp8) begin
         errors++; $display("FAIL reset_cnt got=%h exp=%h", {cnt_r, cnt_b, cnt_c, cnt_g}, exp8);
      end
      rst_n = 1'b1;
      repeat (5) tick();
      checks++;
      if ({busy, valid, s_scale} !== 4'b0) begin
         errors++; $display("FAIL idle_no_start got=%b exp=0000", {busy, valid, s_scale});
      end
   endtask

   task automatic test_single_scan();
      run_scan(1'b0, 0, 5, 2'b10, 1'b0, 2'b00, -1, -1);
      checks++;
      if (prev[0] != 10 || prev[1] != 10 || prev[2] != 10 || prev[3] != 10) begin
         errors++; $display("FAIL period10_model got=%0d,%0d,%0d,%0d exp=10 each", prev[0], prev[1], prev[2], prev[3]);
      end
   endtask

   task automatic test_settle_only();
      run_scan(1'b0, 1, 1, 2'b01, 1'b0, 2'b00, -1, -1);
      checks++;
      if ({cnt_r, cnt_b, cnt_c, cnt_g} !== 32'h0) begin
         errors++; $display("FAIL settle_edges_ignored got=%h exp=0", {cnt_r, cnt_b, cnt_c, cnt_g});
      end
   endtask

   task automatic test_saturation();
      run_scan(1'b0, 0, 1, 2'b11, 1'b0, 2'b00, -1, -1);
      checks++;
      if ({cnt5_r, cnt5_b, cnt5_c, cnt5_g} !== {4{5'd31}}) begin
         errors++; $display("FAIL saturate_31 got=%h exp=%h", {cnt5_r, cnt5_b, cnt5_c, cnt5_g}, {4{5'd31}});
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 4; i++) begin
         run_scan(1'b0, int'($urandom_range(0, 2)), int'($urandom_range(1, 12)),
                  2'($urandom_range(0, 3)), 1'b0, 2'b00, -1, -1);
      end
   endtask

   task automatic test_back_to_back();
      logic [1:0] n;
      n = 2'($urandom_range(0, 3));
      run_scan(1'b0, 2, 1, 2'b01, 1'b1, n, -1, -1);
      run_scan(1'b1, 0, 4, n, 1'b0, 2'b00, -1, -1);
   endtask

   task automatic test_abort();
      run_scan(1'b0, 2, 1, 2'b10, 1'b1, 2'b00, P + S + 10, -1);
   endtask

   task automatic test_abort_done();
      run_scan(1'b0, 0, 3, 2'b01, 1'b1, 2'b11, SCAN, -1);
   endtask

   task automatic test_reset_mid();
      run_scan(1'b0, 0, 5, 2'b10, 1'b0, 2'b00, -1, 2 * P + S + 20);
      run_scan(1'b0, 0, 7, 2'b11, 1'b0, 2'b00, -1, -1);
   endtask

   initial begin
      test_reset();
      test_single_scan();
      test_settle_only();
      test_saturation();
      test_random();
      test_back_to_back();
      test_abort();
      test_abort_done();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
